// File: rtl/approx_pkg.sv
// Shared types and width helpers for the approximate-adder error monitor.
package approx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  function automatic int cnt_w(input int window);
    return $clog2(window + 1);
  endfunction

  function automatic int sum_w(input int n, input int window);
    return n + 1 + cnt_w(window);
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// Sample stream handshake: operand pair plus approximate sum.
interface approx_err_monitor_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] approx_sum;

  modport master (
    output in_valid, a, b, approx_sum,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, approx_sum,
    output in_ready
  );
endinterface

// File: rtl/approx_err_monitor_abs_diff.sv
// Unsigned absolute difference |x - y|.
module abs_diff #(
  parameter int W = 9
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic [W-1:0] o_d
);
  assign o_d = (i_x >= i_y) ? (i_x - i_y)
                            : (i_y - i_x);
endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics for the reduced-carry approximate adder.
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int WINDOW = 256,
  localparam int CNT_W  = cnt_w(WINDOW),
  localparam int SUM_W  = sum_w(N, WINDOW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  approx_err_monitor_if.slave  s_in,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sample_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [SUM_W-1:0]     err_sum,
  output logic [N:0]           err_max
);

  state_t r_state;
  state_t w_next;

  logic             r_s1_vld;
  logic [N:0]       r_s1_ex;
  logic [N:0]       r_s1_ap;
  logic             r_s2_vld;
  logic             r_s2_mis;
  logic [N:0]       r_s2_err;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ecnt;
  logic [SUM_W-1:0] r_esum;
  logic [N:0]       r_emax;

  logic       w_ready;
  logic       w_acc;
  logic       w_last;
  logic       w_clr;
  logic [N:0] w_err;

  assign w_ready = (r_state == RUN) &&
                   (r_cnt < CNT_W'(WINDOW));
  assign w_acc   = s_in.in_valid & w_ready;
  assign w_last  = w_acc &&
                   (r_cnt == CNT_W'(WINDOW - 1));
  assign w_clr   = start &&
                   ((r_state == IDLE) ||
                    (r_state == DONE));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = RUN;
      RUN:   if (w_last) w_next = DRAIN;
      // last sample is in stage 2 once stage 1 empties
      DRAIN: if (!r_s1_vld) w_next = DONE;
      DONE:  if (start) w_next = RUN;
      default: w_next = IDLE;
    endcase
  end

  abs_diff #(.W(N + 1)) u_abs (
    .i_x (r_s1_ex),
    .i_y (r_s1_ap),
    .o_d (w_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_s1_vld <= 1'b0;
      r_s1_ex  <= '0;
      r_s1_ap  <= '0;
      r_s2_vld <= 1'b0;
      r_s2_mis <= 1'b0;
      r_s2_err <= '0;
      r_cnt    <= '0;
      r_ecnt   <= '0;
      r_esum   <= '0;
      r_emax   <= '0;
    end else begin
      r_state  <= w_next;
      r_s1_vld <= w_acc;
      r_s1_ex  <= {1'b0, s_in.a} + {1'b0, s_in.b};
      r_s1_ap  <= {1'b0, s_in.approx_sum};
      r_s2_vld <= r_s1_vld;
      r_s2_err <= w_err;
      r_s2_mis <= |w_err;
      if (w_clr) begin
        r_cnt  <= '0;
        r_ecnt <= '0;
        r_esum <= '0;
        r_emax <= '0;
      end else begin
        if (w_acc)
          r_cnt <= r_cnt + 1'b1;
        if (r_s2_vld) begin
          r_ecnt <= r_ecnt + CNT_W'(r_s2_mis);
          r_esum <= r_esum + SUM_W'(r_s2_err);
          if (r_s2_err > r_emax)
            r_emax <= r_s2_err;
        end
      end
    end
  end

  assign s_in.in_ready = w_ready;
  assign busy       = (r_state == RUN) ||
                      (r_state == DRAIN);
  assign done       = (r_state == DONE);
  assign sample_cnt = r_cnt;
  assign err_cnt    = r_ecnt;
  assign err_sum    = r_esum;
  assign err_max    = r_emax;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed scoreboard bench for approx_err_monitor (N=8, WINDOW=4).
module tb_approx_err_monitor;
  import approx_pkg::*;

  localparam int N      = 8;
  localparam int WINDOW = 4;
  localparam int CNT_W  = cnt_w(WINDOW);
  localparam int SUM_W  = sum_w(N, WINDOW);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] err_sum;
  logic [N:0]       err_max;

  int tests = 0;
  int fails = 0;
  int q[$];

  approx_err_monitor_if #(.N(N)) ifc ();

  approx_err_monitor #(
    .N      (N),
    .WINDOW (WINDOW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_in       (ifc.slave),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .err_sum    (err_sum),
    .err_max    (err_max)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int model_err(input int a,
                                   input int b,
                                   input int s);
    int ex;
    ex = a + b;
    return (ex > s) ? ex - s : s - ex;
  endfunction

  task automatic send(input logic v,
                      input logic [7:0] a,
                      input logic [7:0] b,
                      input logic [7:0] s);
    ifc.in_valid   = v;
    ifc.a          = a;
    ifc.b          = b;
    ifc.approx_sum = s;
    if (v && ifc.in_ready)
      q.push_back(model_err(a, b, s));
    step();
    ifc.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic check_window(input string tag);
    int c, ec, sm, mx, e;
    c = 0; ec = 0; sm = 0; mx = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      c++;
      if (e != 0) ec++;
      sm += e;
      if (e > mx) mx = e;
    end
    chk({tag, "_cnt"},  sample_cnt, c);
    chk({tag, "_ecnt"}, err_cnt, ec);
    chk({tag, "_sum"},  err_sum, sm);
    chk({tag, "_max"},  err_max, mx);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_rdy"},   ifc.in_ready, 0);
    chk({tag, "_cnt"},   sample_cnt, 0);
    chk({tag, "_ecnt"},  err_cnt, 0);
    chk({tag, "_sum"},   err_sum, 0);
    chk({tag, "_max"},   err_max, 0);
  endtask

  logic [7:0] ta [4] = '{8'h0F, 8'hFF, 8'h80, 8'h03};
  logic [7:0] tb_[4] = '{8'h01, 8'h01, 8'h80, 8'h04};
  logic [7:0] ts [4] = '{8'h00, 8'hF0, 8'h00, 8'h07};
  logic [7:0] za [4] = '{8'h11, 8'h01, 8'h7F, 8'h40};
  logic [7:0] zb [4] = '{8'h22, 8'h02, 8'h00, 8'h3F};
  logic [7:0] zs [4] = '{8'h33, 8'h03, 8'h7F, 8'h7F};

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.a          = '0;
    ifc.b          = '0;
    ifc.approx_sum = '0;
    step();
    step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // basic back-to-back window
    pulse_start();
    chk("basic_rdy", ifc.in_ready, 1);
    chk("basic_busy", busy, 1);
    for (int i = 0; i < 4; i++)
      send(1'b1, ta[i], tb_[i], ts[i]);
    chk("basic_rdy_off", ifc.in_ready, 0);
    chk("basic_done_t0", done, 0);
    step();
    chk("basic_done_t1", done, 0);
    step();
    chk("basic_done_t2", done, 1);
    chk("basic_sum_k", err_sum, 288);
    chk("basic_max_k", err_max, 256);
    chk("basic_ecnt_k", err_cnt, 3);
    check_window("basic");

    // restart from DONE, then gapped window
    pulse_start();
    chk_zero_stats: begin
      chk("restart_done", done, 0);
      chk("restart_cnt", sample_cnt, 0);
      chk("restart_ecnt", err_cnt, 0);
      chk("restart_sum", err_sum, 0);
      chk("restart_max", err_max, 0);
      chk("restart_rdy", ifc.in_ready, 1);
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, ta[i], tb_[i], ts[i]);
      if (i < 3) begin
        send(1'b0, 8'hAA, 8'h55, 8'h12);
        send(1'b0, 8'h5A, 8'hA5, 8'h34);
      end
    end
    chk("gap_rdy_off", ifc.in_ready, 0);
    send(1'b1, 8'hFF, 8'hFF, 8'h00);
    chk("gap_no5th", sample_cnt, 4);
    wait_done("gap");
    check_window("gap");

    // zero-error window
    pulse_start();
    for (int i = 0; i < 4; i++)
      send(1'b1, za[i], zb[i], zs[i]);
    wait_done("zero");
    chk("zero_sum_k", err_sum, 0);
    check_window("zero");

    // start during RUN is ignored
    pulse_start();
    send(1'b1, ta[0], tb_[0], ts[0]);
    send(1'b1, ta[1], tb_[1], ts[1]);
    step();
    pulse_start();
    chk("ign_cnt", sample_cnt, 2);
    chk("ign_busy", busy, 1);
    chk("ign_sum", err_sum, 32);
    send(1'b1, ta[2], tb_[2], ts[2]);
    send(1'b1, 8'h00, 8'h00, 8'hFF);
    wait_done("ign");
    check_window("ign");

    // reset mid-window with samples in flight
    pulse_start();
    for (int i = 0; i < 3; i++)
      send(1'b1, ta[i], tb_[i], ts[i]);
    rst = 1'b1;
    step();
    rst = 1'b0;
    q.delete();
    chk_zero("midrst");
    chk("midrst_state", dut.r_state, IDLE);
    for (int i = 0; i < 3; i++)
      send(1'b1, ta[i], tb_[i], ts[i]);
    chk("idle_cnt", sample_cnt, 0);
    chk("idle_sum", err_sum, 0);
    chk("idle_busy", busy, 0);
    chk("idle_q", q.size(), 0);

    // recovery window after reset
    pulse_start();
    for (int i = 3; i >= 0; i--)
      send(1'b1, ta[i], tb_[i], ts[i]);
    wait_done("recov");
    check_window("recov");

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-statistics block that sits directly downstream of the reduced-carry approximate adder. It accepts operand pairs together with the approximate sum the adder produced, computes the exact N+1-bit sum internally, and accumulates error metrics over a fixed window of samples. Results are sample count, mismatch count, sum of absolute errors and maximum absolute error. They are read by the characterisation testbench and, later, by an on-chip calibration controller.

## Interface
- N, 8, operand / approximate-sum width
- WINDOW, 256, samples per measurement window (≥1)
- CNT_W, $clog2(WINDOW+1), derived localparam, counter width
- SUM_W, N+1+CNT_W, derived localparam, error-sum width (cannot overflow)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse: clear statistics and begin a window
- in_valid  in  1  operand/result triple valid
- in_ready  out  1  block accepts a triple this cycle
- a  in  N  operand A
- b  in  N  operand B
- approx_sum  in  N  approximate adder output for (a, b)
- busy  out  1  window in progress (RUN or DRAIN)
- done  out  1  statistics final, held until next start or rst
- sample_cnt  out  CNT_W  triples accepted in current window
- err_cnt  out  CNT_W  samples with nonzero error
- err_sum  out  SUM_W  Σ|exact − approx|
- err_max  out  N+1  max |exact − approx|

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE. Reset state IDLE.
- IDLE/DONE + start → RUN:
  - sample_cnt, err_cnt, err_sum and err_max are cleared.
  - done is cleared.
- RUN: in_ready=1 while sample_cnt < WINDOW. A sample is accepted when in_valid & in_ready.
- On the WINDOW-th accept → DRAIN. in_ready=0 from the following cycle onward.
- DRAIN lasts until the pipeline is empty (2 cycles), then → DONE with done=1.
- start while in RUN or DRAIN is ignored.
- exact = {1'b0,a} + {1'b0,b} (N+1 bits).
- err = |exact − {1'b0,approx_sum}|, computed as unsigned abs difference. Correct for either sign.
- Mismatch when err ≠ 0.
- Accumulate on each valid stage-2 sample:
  - err_sum += err
  - err_cnt += mismatch
  - err_max = max(err_max, err)
- sample_cnt increments at accept time, not at accumulate time.
- rst at any point, including mid-window or mid-drain:
  - Pipeline valids, counters and statistics go to 0.
  - State → IDLE.
  - done=0, busy=0, in_ready=0.

## Timing
- All outputs reset to 0.
- Stage 1 (edge after accept): register exact, approx and a valid bit.
- Stage 2 (next edge): register err and mismatch, and update the accumulators.
- Latency: sample accepted at edge t is reflected in the statistics after edge t+2.
- done rises after edge t_last+2, together with the final statistics. It is never visible before them.
- Throughput: 1 sample/cycle, with no bubbles required. in_valid may drop at any time with no effect.
- in_ready is a function of registered state only; there is no combinational path from in_valid.
- start pulse at edge t: in_ready=1 from after edge t.

## Structure
- Shared package approx_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - Width helper functions for CNT_W/SUM_W.
- One sub-module, abs_diff #(W): combinational unsigned |x−y|, used in stage 2.
- Pipeline registers, FSM and accumulators stay in the top module.

## Test plan
- **Basic window.** N=8, WINDOW=4, back-to-back triples (0x0F,0x01,0x00), (0xFF,0x01,0xF0), (0x80,0x80,0x00), (0x03,0x04,0x07).
  - Statistics: sample_cnt=4, err_cnt=3, err_sum=288, err_max=256.
  - done rises 2 edges after the 4th accept.
- **Backpressure/gaps.** Same four triples with in_valid toggling 1-0-0-1.
  - Identical final statistics.
  - in_ready=0 after the 4th accept; a 5th valid triple is not accepted.
- **Zero-error window.** Four triples with approx_sum=a+b mod 256 and no carry-out, e.g. (0x11,0x22,0x33).
  - err_cnt=0, err_sum=0, err_max=0.
- **start ignored.** Pulse start during RUN after 2 samples.
  - Counters are not cleared and the window completes normally.
- **Restart from DONE.** Pulse start while in DONE.
  - done=0 and all statistics=0 on the next cycle.
  - A new window accumulates from zero.
- **Reset mid-window.** Assert rst after 3 accepts with samples still in the pipeline.
  - The next cycle shows all outputs 0 and state IDLE.
  - Inputs are ignored until start.
